// File: rtl/clkdiv_meter_pkg.sv
// rtl/clkdiv_meter_pkg.sv - shared FSM encoding and defaults for the divided-clock period meter
package clkdiv_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int DEFAULT_W           = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - multi-flop synchronizer with registered rising-edge detect
module sync_rise_det
    import clkdiv_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/clkdiv_period_meter.sv
// rtl/clkdiv_period_meter.sv - measures divided-clock period (and high time with PERIOD_METER_DUTY_EN)
module clkdiv_period_meter
    import clkdiv_meter_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    input  logic         restart,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);

    localparam logic [W-1:0] CNT_MAX = '1;

    meter_state_t state;
    logic [W-1:0] cnt;
    logic         s;
    logic         rise;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .s    (s),
        .rise (rise)
    );

    // restart outranks every other event, including a coincident rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (restart) begin
                state   <= IDLE;
                cnt     <= '0;
                timeout <= 1'b0;
            end else if (state == IDLE) begin
                if (rise) begin
                    cnt   <= W'(1);
                    state <= MEASURE;
                end
            end else begin
                if (rise) begin
                    period  <= cnt;
                    valid   <= 1'b1;
                    timeout <= 1'b0;
                    cnt     <= W'(1);
                end else if (cnt == CNT_MAX) begin
                    timeout <= 1'b1;
                    state   <= IDLE;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [W-1:0] hcnt;
    logic [W-1:0] high_time_q;

    // hcnt never exceeds cnt, so it cannot wrap before cnt saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            high_time_q <= '0;
        end else if (!restart) begin
            if (state == IDLE) begin
                if (rise) hcnt <= W'(1);
            end else if (rise) begin
                high_time_q <= hcnt;
                hcnt        <= W'(1);
            end else if (cnt != CNT_MAX) begin
                hcnt <= hcnt + W'(s);
            end
        end
    end

    assign high_time = high_time_q;
`else
    logic unused_s;
    assign unused_s  = s;
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clkdiv_period_meter.sv
// tb/tb_clkdiv_period_meter.sv - scoreboard bench for clkdiv_period_meter
module tb_clkdiv_period_meter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig_in = 1'b0;
    logic         restart = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    typedef struct {
        int period;
        int high;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid = 0;

    clkdiv_period_meter #(
        .W(W),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .restart  (restart),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hi(input int h);
`ifdef PERIOD_METER_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid period=%0d high_time=%0d cyc=%0d", period, high_time, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (period !== W'(e.period)) begin
                    errors++;
                    $display("FAIL period got=%0d exp=%0d cyc=%0d", period, e.period, cyc);
                end
                checks++;
                if (high_time !== W'(e.high)) begin
                    errors++;
                    $display("FAIL high_time got=%0d exp=%0d cyc=%0d", high_time, e.high, cyc);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_valid != e.gap) begin
                        errors++;
                        $display("FAIL valid_spacing got=%0d exp=%0d cyc=%0d", cyc - last_valid, e.gap, cyc);
                    end
                end
            end
            last_valid = cyc;
        end
    end

    task automatic drive_wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s period=%0d high_time=%0d valid=%0b timeout=%0b exp all 0",
                     name, period, high_time, valid, timeout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_steady_period();
        sb.push_back('{8, hi(4), 0});
        for (int i = 0; i < 6; i++) sb.push_back('{8, hi(4), 8});
        drive_wave(4, 4, 8);
    endtask

    task automatic test_period_change();
        sb.push_back('{8, hi(4), 8});
        sb.push_back('{16, hi(4), 16});
        sb.push_back('{20, hi(10), 20});
        sb.push_back('{20, hi(10), 20});
        drive_wave(4, 12, 1);
        drive_wave(10, 10, 3);
    endtask

    task automatic test_restart();
        sb.push_back('{20, hi(10), 20});
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        pulse_restart();
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        sb.push_back('{8, hi(4), 0});
        sb.push_back('{8, hi(4), 8});
        drive_wave(4, 4, 3);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL restart_timeout got=%0b exp=0", timeout);
        end
    endtask

    task automatic test_timeout();
        pulse_restart();
        repeat (2) @(negedge clk);
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (61) @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got=%0b exp=0", timeout);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_at_63 got=%0b exp=1", timeout);
        end
        sb.push_back('{8, hi(4), 0});
        drive_wave(4, 4, 2);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got=%0b exp=0", timeout);
        end
    endtask

    task automatic test_async_reset();
        sb.push_back('{8, hi(4), 8});
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back('{8, hi(4), 0});
        drive_wave(4, 4, 2);
    endtask

    task automatic test_duty();
        sb.push_back('{8, hi(4), 8});
        sb.push_back('{8, hi(3), 8});
        sb.push_back('{8, hi(3), 8});
        drive_wave(3, 5, 3);
    endtask

    initial begin
        test_reset();
        test_steady_period();
        test_period_change();
        test_restart();
        test_timeout();
        test_async_reset();
        test_duty();
        repeat (10) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_valids got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
